// File: rtl/slice_sequencer.sv
// Time-multiplexed sequencer for the shared 4-bit combination slice: captures an
// A/B operand pair, steps one slice per clock, and returns the assembled word.
module slice_sequencer #(
  parameter int NUM_SLICES = 9,
  localparam int W = 4 * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic         busy,
  output logic [3:0]   slice_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_SLICES - 1);

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_out_c;
  logic [W-1:0] w_acc_next;
  logic [3:0]   r_idx;
  logic [3:0]   w_a_nib;
  logic [3:0]   w_b_nib;
  logic [3:0]   w_slice;
  logic         w_last;

  // Slice datapath: one nibble of each captured operand selected by the index.
  always_comb begin
    w_a_nib    = r_a[{r_idx, 2'b00} +: 4];
    w_b_nib    = r_b[{r_idx, 2'b00} +: 4];
    w_slice[0] = ~w_a_nib[0];
    w_slice[1] = ~w_b_nib[0];
    w_slice[2] = ~w_b_nib[1];
    w_slice[3] = ~((w_a_nib[1] | w_a_nib[2]) & (w_b_nib[1] | w_b_nib[2]) &
                   (w_a_nib[3] | w_b_nib[3]));
    w_acc_next = r_acc;
    w_acc_next[{r_idx, 2'b00} +: 4] = w_slice;
    w_last     = (r_idx == LAST_IDX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; rst is in the sensitivity list, making it async.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // flush overrides every transition; outputs decode only from registered state.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_out_c <= '0;
      r_idx   <= '0;
    end else if (flush) begin
      r_acc   <= '0;
      r_out_c <= '0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            // out_c is loaded once, on entry to DONE, and then held.
            r_out_c <= w_acc_next;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_c     = r_out_c;
  assign slice_idx = r_idx;

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer at NUM_SLICES=9: reset, operand patterns,
// backpressure, flush, async reset, and back-to-back words against a reference model.
module tb_slice_sequencer;

  localparam int NS = 9;
  localparam int W  = 4 * NS;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic         busy;
  logic [3:0]   slice_idx;

  int n_checks = 0;
  int n_errors = 0;

  slice_sequencer #(.NUM_SLICES(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy),
    .slice_idx (slice_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] c;
    logic [3:0] x, y;
    c = '0;
    for (int k = 0; k < NS; k++) begin
      x = a[4*k +: 4];
      y = b[4*k +: 4];
      c[4*k]   = !x[0];
      c[4*k+1] = !y[0];
      c[4*k+2] = !y[1];
      c[4*k+3] = !((x[1] || x[2]) && (y[1] || y[2]) && (x[3] || y[3]));
    end
    return c;
  endfunction

  // Accept a pair from IDLE, measure edges (acceptance edge inclusive) until out_valid.
  task automatic accept_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] exp, input string tag);
    int lat;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd10);
    check({tag, " out_c"}, 64'(out_c), 64'(exp));
  endtask

  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held_c;
    logic [W-1:0] ra, rb, exp_w;
    logic [W-1:0] exp_q[$];
    int seen, cyc, last_acc, sent, got;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #3;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_c", 64'(out_c), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset slice_idx", 64'(slice_idx), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    accept_and_wait('0, '0, 36'hFFFFFFFFF, "zeros");
    finish_xfer("zeros");
    accept_and_wait(ONES, '0, 36'hEEEEEEEEE, "a_ones");
    finish_xfer("a_ones");
    accept_and_wait('0, ONES, 36'h999999999, "b_ones");
    finish_xfer("b_ones");
    accept_and_wait(ONES, ONES, 36'h000000000, "both_ones");
    finish_xfer("both_ones");

    // Slice index walks 0..8 during RUN.
    in_a = '0; in_b = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("run idx0", 64'(slice_idx), 64'd0);
    check("run busy", 64'(busy), 64'd1);
    check("run in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    check("run idx8", 64'(slice_idx), 64'd8);
    check("run last no valid", 64'(out_valid), 64'd0);
    tick();
    check("done out_valid", 64'(out_valid), 64'd1);
    check("done idx0", 64'(slice_idx), 64'd0);

    // Backpressure: hold out_ready low with a competing in_valid.
    held_c = out_c;
    in_a = ONES; in_b = ONES; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp out_c", 64'(out_c), 64'(held_c));
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    finish_xfer("bp");
    check("bp out_c value", 64'(held_c), 64'h0FFFFFFFFF);
    tick();
    check("bp not accepted", 64'(busy), 64'd0);

    // flush in IDLE with in_valid: pair must not be accepted.
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);
    check("idle flush in_ready", 64'(in_ready), 64'd1);

    // flush at idx=4.
    in_a = '0; in_b = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("flush at idx", 64'(slice_idx), 64'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush idle", 64'(in_ready), 64'd1);
    check("flush busy", 64'(busy), 64'd0);
    check("flush idx", 64'(slice_idx), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("flush no out_valid", 64'(seen), 64'd0);
    accept_and_wait(ONES, '0, 36'hEEEEEEEEE, "post_flush");
    finish_xfer("post_flush");

    // Async reset mid-RUN between edges.
    in_a = '0; in_b = ONES; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst in_ready", 64'(in_ready), 64'd1);
    check("arst idx", 64'(slice_idx), 64'd0);
    check("arst out_valid", 64'(out_valid), 64'd0);
    check("arst out_c", 64'(out_c), 64'd0);
    rst = 1'b0;
    tick();
    accept_and_wait('0, '0, 36'hFFFFFFFFF, "post_rst");
    finish_xfer("post_rst");

    // Back-to-back random words with out_ready held high.
    out_ready = 1'b1;
    cyc = 0; last_acc = 0; sent = 0; got = 0;
    while (got < 6 && cyc < 300) begin
      if (out_valid) begin
        exp_w = exp_q.pop_front();
        check("rand out_c", 64'(out_c), 64'(exp_w));
        got++;
      end
      if (in_ready && sent < 6) begin
        ra = W'({$urandom(), $urandom()});
        rb = W'({$urandom(), $urandom()});
        exp_q.push_back(model(ra, rb));
        in_a = ra; in_b = rb; in_valid = 1'b1;
        if (sent > 0) check("rand II", 64'(cyc - last_acc), 64'd11);
        last_acc = cyc;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (got < 6) begin
        tick();
        cyc++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand words received", 64'(got), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Time-multiplexed controller for the 4-bit combination slice used in the vector-combination datapath. One physical slice is shared across NUM_SLICES word positions. The block accepts an A/B operand pair over a valid/ready handshake and steps a slice index once per clock through the datapath. It assembles the 4-bit results into a NUM_SLICES*4-bit result word and returns it over a second valid/ready handshake. It sits between the operand source and the result consumer and replaces the fully unrolled U1..U3 slice array where area matters more than throughput.

## Interface
- NUM_SLICES, default 9: number of 4-bit slices per word; legal range 1..16.
- W, derived as 4*NUM_SLICES (36 at default): operand and result width.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- flush  input  1  synchronous abort; returns the block to IDLE.
- out_valid  output  1  result held on out_c.
- out_ready  input  1  consumer accepts the result.
- out_c  output  W  result word.
- busy  output  1  high in RUN or DONE.
- slice_idx  output  4  slice currently being processed; 0 outside RUN.

## Operation
- Slice function for index k, with a = A[4k+3:4k] and b = B[4k+3:4k]:
  - c0 = ~a0
  - c1 = ~b0
  - c2 = ~b1
  - c3 = ~((a1|a2) & (b1|b2) & (a3|b3))
- The operands are captured into internal registers on acceptance. in_a and in_b are not sampled after that.
- States:
  - IDLE: in_ready=1. If in_valid, capture the operands, clear the accumulator, set idx=0, and go to RUN.
  - RUN: each cycle, write the slice-k result into accumulator bits [4k+3:4k]. When k==NUM_SLICES-1, go to DONE. Otherwise increment k.
  - DONE: out_valid=1 and out_c = accumulator, held stable until out_ready=1. The cycle with out_valid&&out_ready completes the transfer and returns the block to IDLE.
- in_ready is 0 in RUN and DONE. There is no overlap between words and no input buffering.
- flush takes priority over every other transition:
  - From any state, the next state is IDLE and the accumulator is cleared.
  - A result pending in DONE is discarded and out_valid drops the next cycle.
  - flush in IDLE with in_valid=1: the operand pair is not accepted.
- The slice index is 4 bits wide and never exceeds NUM_SLICES-1. No wrap-around occurs inside RUN.
- NUM_SLICES=1: RUN lasts exactly one cycle.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_c = 0
  - busy = 0
  - slice_idx = 0
  - accumulator = 0
- Acceptance is at edge 0, where in_valid&&in_ready. RUN then occupies edges 1..NUM_SLICES. out_valid rises after edge NUM_SLICES, i.e. NUM_SLICES+1 cycles after acceptance: 10 cycles at the default.
- Minimum initiation interval is NUM_SLICES+2 cycles, when out_ready is held high.
- out_c changes only on entry to DONE, on flush, or on reset. It is never modified while out_valid=1.
- Reset asserted mid-RUN or in DONE clears everything immediately. No partial result is ever presented.
- All outputs are registered or decoded from the state register only. There are no combinational paths from in_valid or out_ready to any output.

## Test plan
- Zero operands: in_a=0, in_b=0. Required: out_c=36'hFFFFFFFFF, with out_valid rising exactly 10 cycles after acceptance.
- Mixed operands:
  - in_a=all ones, in_b=0 gives out_c=36'hEEEEEEEEE.
  - in_a=0, in_b=all ones gives out_c=36'h999999999.
  - Both all ones gives out_c=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_c and out_valid stay stable, in_ready=0, and an in_valid presented meanwhile is not accepted. After out_ready=1, the block is in IDLE the next cycle.
- flush at RUN idx=4, with in_a=0, in_b=0. Required: the block is in IDLE the next cycle, out_valid never rises, and the next word with in_a=all ones, in_b=0 produces 36'hEEEEEEEEE with no residue from the aborted word.
- Async reset asserted mid-RUN, between clock edges. Required: outputs take their reset values immediately, and the first word after deassertion completes with correct latency.
- Randomized back-to-back words with out_ready held high. Required: every result matches a bit-accurate reference model of the slice function, and the initiation interval is 11 cycles.
